// File: rtl/decode_stage.sv
// decode_stage: registers the {pc, instruction} pair coming from fetch and
// splits it into fields for execute. Jumps, zero-conditional branches and
// halt are resolved here and steered back into fetch through branch /
// branch_address. Branch targets come from a small flop-based table that
// has its own write port.
module decode_stage #(
  parameter int NUM_TARGETS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  entry_address,
  input  logic [7:0]  if_pc,
  input  logic [8:0]  if_instr,
  input  logic        zero_flag,
  input  logic        lut_we,
  input  logic [4:0]  lut_waddr,
  input  logic [7:0]  lut_wdata,
  output logic        branch,
  output logic [7:0]  branch_address,
  output logic        id_valid,
  output logic [7:0]  id_pc,
  output logic [8:0]  id_instr,
  output logic [2:0]  id_opcode,
  output logic [2:0]  id_ra,
  output logic [2:0]  id_rb,
  output logic        done,
  output logic [15:0] retired_count
);

  localparam logic [2:0] OP_JMP   = 3'b101;
  localparam logic [2:0] OP_BRZ   = 3'b110;
  localparam logic [8:0] HALT_ENC = 9'b111_111111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    HALT
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [7:0]  pc_reg;
  logic [8:0]  instr_reg;
  // primed_reg marks that the decode register holds a real fetched
  // instruction; until the first capture after start it still holds the
  // reset value and must not be executed or resolved.
  logic        primed_reg;
  logic [15:0] count_reg;
  logic [7:0]  lut_reg [NUM_TARGETS];
  logic [NUM_TARGETS-1:0] lut_hit;

  logic        capture;
  logic        valid_int;
  logic        is_jmp;
  logic        is_brz;
  logic        is_halt;
  logic [7:0]  target;

  // Per-entry write decode for the target table.
  generate
    for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_lut_hit
      assign lut_hit[gi] = lut_we && (lut_waddr == 5'(gi));
    end
  endgenerate

  // Target table: written at the edge, so a same-cycle read sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TARGETS; i++) begin
        lut_reg[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < NUM_TARGETS; i++) begin
        if (lut_hit[i]) begin
          lut_reg[i] <= lut_wdata;
        end
      end
    end
  end

  // Combinational decode of the held instruction.
  assign is_halt = (instr_reg == HALT_ENC);
  assign is_jmp  = (instr_reg[8:6] == OP_JMP);
  assign is_brz  = (instr_reg[8:6] == OP_BRZ);
  // Bit 5 of the instruction is not part of the table index.
  assign target  = lut_reg[instr_reg[4:0]];

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and control outputs; halt is checked before opcode 3'b111
  // so the other 3'b111 encodings fall through as normal instructions.
  always_comb begin
    state_next     = state_reg;
    branch         = 1'b0;
    branch_address = pc_reg;
    valid_int      = 1'b0;
    capture        = 1'b0;
    done           = 1'b0;
    case (state_reg)
      IDLE: begin
        branch         = 1'b1;
        branch_address = entry_address;
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (!primed_reg) begin
          capture = 1'b1;
        end else if (is_halt) begin
          // Register stays frozen on the halt pc from this edge onward.
          branch         = 1'b1;
          branch_address = pc_reg;
          state_next     = HALT;
        end else if (is_jmp || (is_brz && zero_flag)) begin
          branch         = 1'b1;
          branch_address = target;
          capture        = 1'b1;
          state_next     = FLUSH;
        end else if (is_brz) begin
          capture = 1'b1;
        end else begin
          valid_int = 1'b1;
          capture   = 1'b1;
        end
      end
      FLUSH: begin
        // The fall-through instruction captured at the branch edge is dropped.
        capture    = 1'b1;
        state_next = RUN;
      end
      HALT: begin
        branch         = 1'b1;
        branch_address = pc_reg;
        done           = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Decode register: loads the fetch pair whenever the FSM allows capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg     <= 8'h00;
      instr_reg  <= 9'h000;
      primed_reg <= 1'b0;
    end else if (capture) begin
      pc_reg     <= if_pc;
      instr_reg  <= if_instr;
      primed_reg <= 1'b1;
    end
  end

  // Retired-instruction counter, wrapping naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= 16'h0000;
    end else if (valid_int) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  assign id_valid      = valid_int;
  assign id_pc         = pc_reg;
  assign id_instr      = instr_reg;
  assign id_opcode     = instr_reg[8:6];
  assign id_ra         = instr_reg[5:3];
  assign id_rb         = instr_reg[2:0];
  assign retired_count = count_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a simple fetch model (pc register plus
// instruction memory) closes the branch loop; expected values are hand
// computed from the instruction layout of each scenario.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  entry_address = 8'h10;
  logic [7:0]  if_pc;
  logic [8:0]  if_instr;
  logic        zero_flag = 1'b0;
  logic        lut_we = 1'b0;
  logic [4:0]  lut_waddr = 5'd0;
  logic [7:0]  lut_wdata = 8'h00;
  logic        branch;
  logic [7:0]  branch_address;
  logic        id_valid;
  logic [7:0]  id_pc;
  logic [8:0]  id_instr;
  logic [2:0]  id_opcode;
  logic [2:0]  id_ra;
  logic [2:0]  id_rb;
  logic        done;
  logic [15:0] retired_count;

  int n_checks = 0;
  int n_pass = 0;

  logic [8:0] imem [256];
  logic [7:0] fpc;

  decode_stage #(.NUM_TARGETS(32)) dut (
    .clk(clk), .rst(rst), .start(start), .entry_address(entry_address),
    .if_pc(if_pc), .if_instr(if_instr), .zero_flag(zero_flag),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .branch(branch), .branch_address(branch_address), .id_valid(id_valid),
    .id_pc(id_pc), .id_instr(id_instr), .id_opcode(id_opcode),
    .id_ra(id_ra), .id_rb(id_rb), .done(done), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  // Fetch model: loads branch_address when branch is high, else increments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fpc <= 8'h00;
    else if (branch) fpc <= branch_address;
    else fpc <= fpc + 8'd1;
  end
  assign if_pc    = fpc;
  assign if_instr = imem[fpc];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("  ok   %s = %0h", tag, got);
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic fill_normal();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      a = 8'(i);
      imem[i] = {3'b001, a[5:0]};
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic lut_write(input logic [4:0] idx, input logic [7:0] data);
    lut_we = 1'b1;
    lut_waddr = idx;
    lut_wdata = data;
    tick();
    lut_we = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the start edge E0.
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- Scenario A: straight-line code ----------------
    fill_normal();
    imem[8'h11] = 9'b011_101_110;
    imem[8'h13] = 9'b111_111_110;
    entry_address = 8'h10;
    tick();
    reset_dut();
    check("rst_branch", branch, 1);
    check("rst_baddr", branch_address, 8'h10);
    check("rst_valid", id_valid, 0);
    check("rst_done", done, 0);
    check("rst_id_pc", id_pc, 0);
    check("rst_id_instr", id_instr, 0);
    check("rst_retired", retired_count, 0);
    pulse_start();
    check("A_e0_valid", id_valid, 0);
    check("A_e0_branch", branch, 0);
    tick();
    check("A_e1_pc", id_pc, 8'h10);
    check("A_e1_valid", id_valid, 1);
    check("A_e1_instr", id_instr, 9'h050);
    check("A_e1_opcode", id_opcode, 3'd1);
    check("A_e1_ra", id_ra, 3'd2);
    check("A_e1_rb", id_rb, 3'd0);
    tick();
    check("A_e2_pc", id_pc, 8'h11);
    check("A_e2_opcode", id_opcode, 3'd3);
    check("A_e2_ra", id_ra, 3'd5);
    check("A_e2_rb", id_rb, 3'd6);
    check("A_e2_valid", id_valid, 1);
    tick();
    check("A_e3_pc", id_pc, 8'h12);
    check("A_e3_valid", id_valid, 1);
    tick();
    check("A_e4_pc", id_pc, 8'h13);
    check("A_e4_instr", id_instr, 9'h1FE);
    check("A_e4_valid", id_valid, 1);
    check("A_e4_branch", branch, 0);
    check("A_e4_done", done, 0);
    tick();
    check("A_retired", retired_count, 4);

    // ---------------- Scenario B: JMP, back-to-back, reset in FLUSH ----
    fill_normal();
    imem[8'h12] = 9'b101_000_011;
    imem[8'h13] = 9'b101_000_100;
    imem[8'h41] = 9'b101_000_011;
    reset_dut();
    lut_write(5'd3, 8'h40);
    lut_write(5'd4, 8'h60);
    pulse_start();
    ticks(3);
    check("B_jmp_pc", id_pc, 8'h12);
    check("B_jmp_branch", branch, 1);
    check("B_jmp_baddr", branch_address, 8'h40);
    check("B_jmp_valid", id_valid, 0);
    tick();
    check("B_flush_pc", id_pc, 8'h13);
    check("B_flush_valid", id_valid, 0);
    check("B_flush_branch", branch, 0);
    tick();
    check("B_target_pc", id_pc, 8'h40);
    check("B_target_valid", id_valid, 1);
    check("B_target_branch", branch, 0);
    check("B_retired", retired_count, 2);
    tick();
    check("B_jmp2_pc", id_pc, 8'h41);
    check("B_jmp2_baddr", branch_address, 8'h40);
    tick();
    rst = 1'b1;
    #1;
    check("B_arst_branch", branch, 1);
    check("B_arst_baddr", branch_address, 8'h10);
    check("B_arst_valid", id_valid, 0);
    check("B_arst_done", done, 0);
    check("B_arst_id_pc", id_pc, 0);
    check("B_arst_id_instr", id_instr, 0);
    check("B_arst_retired", retired_count, 0);
    tick();
    rst = 1'b0;
    tick();
    pulse_start();
    ticks(3);
    check("B_lut_cleared_baddr", branch_address, 8'h00);
    check("B_lut_cleared_branch", branch, 1);

    // ---------------- Scenario C: BRZ not taken / taken ----------------
    fill_normal();
    imem[8'h12] = 9'b110_000_011;
    zero_flag = 1'b0;
    reset_dut();
    lut_write(5'd3, 8'h40);
    pulse_start();
    ticks(3);
    check("C_nt_pc", id_pc, 8'h12);
    check("C_nt_valid", id_valid, 0);
    check("C_nt_branch", branch, 0);
    tick();
    check("C_nt_next_pc", id_pc, 8'h13);
    check("C_nt_next_valid", id_valid, 1);
    tick();
    check("C_nt_retired", retired_count, 3);

    fill_normal();
    imem[8'h12] = 9'b110_100_011;
    zero_flag = 1'b1;
    reset_dut();
    lut_write(5'd3, 8'h40);
    pulse_start();
    ticks(3);
    check("C_tk_branch", branch, 1);
    check("C_tk_baddr", branch_address, 8'h40);
    check("C_tk_valid", id_valid, 0);
    tick();
    check("C_tk_flush_valid", id_valid, 0);
    check("C_tk_flush_branch", branch, 0);
    tick();
    check("C_tk_target_pc", id_pc, 8'h40);
    check("C_tk_target_valid", id_valid, 1);
    zero_flag = 1'b0;

    // ---------------- Scenario E: HALT ----------------
    fill_normal();
    imem[8'h15] = 9'h1FF;
    reset_dut();
    pulse_start();
    ticks(6);
    check("E_halt_pc", id_pc, 8'h15);
    check("E_halt_branch", branch, 1);
    check("E_halt_baddr", branch_address, 8'h15);
    check("E_halt_valid", id_valid, 0);
    check("E_halt_done_early", done, 0);
    check("E_retired", retired_count, 5);
    tick();
    check("E_done", done, 1);
    start = 1'b1;
    for (int i = 0; i < 22; i++) begin
      tick();
      if (i == 3) start = 1'b0;
      check($sformatf("E_spin%0d_baddr", i), {branch, branch_address}, {1'b1, 8'h15});
      check($sformatf("E_spin%0d_done", i), {done, id_valid, id_pc}, {1'b1, 1'b0, 8'h15});
    end
    check("E_retired_frozen", retired_count, 5);
    rst = 1'b1;
    #1;
    check("E_arst_done", done, 0);
    check("E_arst_branch", branch, 1);
    check("E_arst_baddr", branch_address, 8'h10);
    check("E_arst_id_pc", id_pc, 0);
    check("E_arst_id_instr", id_instr, 0);
    check("E_arst_retired", retired_count, 0);
    check("E_arst_valid", id_valid, 0);
    tick();
    rst = 1'b0;
    tick();

    // ---------------- Scenario F: table write during JMP decode ----------
    fill_normal();
    imem[8'h12] = 9'b101_000_011;
    imem[8'h42] = 9'b101_000_011;
    reset_dut();
    lut_write(5'd3, 8'h40);
    pulse_start();
    ticks(3);
    lut_we = 1'b1;
    lut_waddr = 5'd3;
    lut_wdata = 8'h77;
    #1;
    check("F_old_baddr", branch_address, 8'h40);
    tick();
    lut_we = 1'b0;
    tick();
    check("F_target_pc", id_pc, 8'h40);
    ticks(2);
    check("F_jmp2_pc", id_pc, 8'h42);
    check("F_new_baddr", branch_address, 8'h77);
    check("F_new_branch", branch, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
